// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one single-port data memory between two requesters
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rr;
    logic   any_req;
    logic   winner;

    // Arbitration: a lone requester wins; on a tie the round-robin pointer decides
    always_comb begin
        any_req = r0_req | r1_req;
        winner  = (r0_req && r1_req) ? rr : r1_req;
    end

    // Next-state logic: one grant walks IDLE -> ACCESS -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: latch request at grant, drive memory for one cycle, capture read data, pulse ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr        <= 1'b0;
            owner     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner     <= winner;
                        rr        <= ~winner;
                        mem_addr  <= winner ? r1_addr  : r0_addr;
                        mem_wdata <= winner ? r1_wdata : r0_wdata;
                        mem_we    <= winner ? r1_we    : r0_we;
                    end
                end
                S_ACCESS: begin
                    // mem_we doubles as the latched write flag for this access
                    mem_we <= 1'b0;
                    if (!mem_we) begin
                        if (owner) r1_rdata <= mem_rdata;
                        else       r0_rdata <= mem_rdata;
                    end
                    r0_ack <= ~owner;
                    r1_ack <= owner;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule
